rom_access_arbiter: RTL
=======================

// Module: rom_access_arbiter
// PURPOSE
//  Shares one synchronous single-port ROM (1-cycle registered read) between two requesters.
//  Port 0 is instruction fetch; port 1 is constant/data load.
//  Round-robin grant, valid/ready request handshake, one-cycle response pulse per access.
//  Sits between the fetch/load units and the ROM instance; drives the ROM address, samples its q.
// PARAMETERS
//  DATA_WIDTH  32  ROM word width; width of rom_q and pN_rsp_data
//  ADDR_WIDTH  32  requester and ROM address width
//  DEPTH       50  number of ROM words; range-check bound
// PORTS
//  clk           in   1           single clock, all logic on posedge
//  reset         in   1           synchronous, active-high
//  p0_valid      in   1           port 0 request; held with p0_addr until p0_ready
//  p0_addr       in   ADDR_WIDTH  port 0 word address
//  p0_ready      out  1           port 0 request accepted this cycle (combinational)
//  p0_rsp_valid  out  1           port 0 response pulse, 1 cycle
//  p0_rsp_data   out  DATA_WIDTH  port 0 read data, valid with p0_rsp_valid
//  p0_rsp_err    out  1           port 0 out-of-range flag, valid with p0_rsp_valid
//  p1_*          --   --          identical set for port 1
//  rom_addr      out  ADDR_WIDTH  registered address to ROM addr
//  rom_q         in   DATA_WIDTH  ROM q; valid 1 cycle after rom_addr is sampled
//  busy          out  1           high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rom_addr=0, all rsp_valid/rsp_err=0, rsp_data=0, last_grant=1, busy=0.
//  FSM: IDLE -> ADDR -> READ -> RESP -> IDLE. Exactly one access in flight.
//   IDLE: if any pN_valid, grant one port; assert pN_ready that cycle; register rom_addr=pN_addr
//         and owner=N; go ADDR. No valid: stay IDLE.
//   ADDR: ROM samples rom_addr at the end of this cycle. Go READ.
//   READ: rom_q valid. Capture it into the owner's rsp_data register. Go RESP.
//   RESP: owner's rsp_valid=1 for this cycle only. Go IDLE.
//  pN_ready is asserted only in IDLE. It is never asserted for both ports in the same cycle.
//  Latency: accept in cycle t -> pN_rsp_valid in cycle t+3. Max throughput is 1 access per 4 cycles.
//  Arbitration:
//   - One port valid: that port is granted.
//   - Both valid: grant the port != last_grant; last_grant updates on every grant.
//   - After reset, a tie goes to port 0.
//  The non-owner's rsp_valid stays 0. Each rsp_data holds its last value until overwritten.
//  A requester may deassert valid before ready; no grant is issued for it. Addr changes while
//  valid is high and not yet accepted are allowed (the value sampled at grant is used).
//  rom_addr holds its value in all states except the IDLE grant cycle.
//  Reset mid-access: return to IDLE immediately; the in-flight response is dropped (no rsp_valid).
//   last_grant=1.
// CONFIGURATION
//  ROM_RANGE_CHECK_EN defined:
//   - At grant, the address is compared against DEPTH.
//   - addr >= DEPTH: rom_addr is not updated and the sequence still runs.
//   - In RESP: rsp_data=0, rsp_err=1. Latency is unchanged (t+3).
//  ROM_RANGE_CHECK_EN undefined: no compare; pN_rsp_err tied 0; the address is passed unchanged.
// TESTING
//  1 Reset, p0_valid with addr=5 (ROM[5]=0x20080005) -> p0_ready at t, rom_addr=5 at t+1,
//    p0_rsp_valid=1 with data 0x20080005 at t+3, busy for t+1..t+3.
//  2 p0 and p1 valid together after reset (addr 1, 2) -> p0 granted first, p1 granted on next IDLE;
//    responses 4 cycles apart, each only on its own port.
//  3 Both held valid for 8 accesses -> grants strictly alternate 0,1,0,1...; no port starves.
//  4 reset asserted in READ -> next cycle IDLE, busy=0, no rsp_valid on either port, rom_addr=0.
//  5 ROM_RANGE_CHECK_EN, p1 addr=50 -> p1_rsp_valid at t+3 with data=0, err=1; rom_addr unchanged.
//    Without the macro: err=0.
//  6 p1_valid pulsed for 1 cycle while busy -> no p1_ready, no p1 response afterwards.

Source files
------------

// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter sharing one registered-read ROM between fetch (p0) and load (p1); accept at t, rsp at t+3, one access in flight.
// Requests wait on ready (IDLE only); ROM_RANGE_CHECK_EN adds an out-of-range check returning data=0, err=1.
module rom_access_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 50
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_valid,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    output logic                  p0_ready,
    output logic                  p0_rsp_valid,
    output logic [DATA_WIDTH-1:0] p0_rsp_data,
    output logic                  p0_rsp_err,
    input  logic                  p1_valid,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    output logic                  p1_ready,
    output logic                  p1_rsp_valid,
    output logic [DATA_WIDTH-1:0] p1_rsp_data,
    output logic                  p1_rsp_err,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ADDR, READ, RESP} state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    owner;
    logic                    last_grant;
    logic                    grant0;
    logic                    grant1;
    logic [ADDR_WIDTH-1:0]   grant_addr;
    logic                    grant_oob;
    logic                    oob_flag;

    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the port that did not win last time goes first.
                if (p0_valid && (!p1_valid || last_grant)) begin
                    grant0 = 1'b1;
                end else if (p1_valid) begin
                    grant1 = 1'b1;
                end
                if (grant0 || grant1) begin
                    state_next = ADDR;
                end
            end
            ADDR:    state_next = READ;
            READ:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign grant_addr   = grant1 ? p1_addr : p0_addr;
    assign p0_ready     = grant0;
    assign p1_ready     = grant1;
    assign busy         = (state != IDLE);
    assign p0_rsp_valid = (state == RESP) && !owner;
    assign p1_rsp_valid = (state == RESP) && owner;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rom_addr    <= '0;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            p0_rsp_data <= '0;
            p1_rsp_data <= '0;
        end else begin
            state <= state_next;
            if (grant0 || grant1) begin
                owner      <= grant1;
                last_grant <= grant1;
                if (!grant_oob) begin
                    rom_addr <= grant_addr;
                end
            end
            if (state == READ) begin
                if (!owner) begin
                    p0_rsp_data <= oob_flag ? '0 : rom_q;
                end else begin
                    p1_rsp_data <= oob_flag ? '0 : rom_q;
                end
            end
        end
    end

`ifdef ROM_RANGE_CHECK_EN
    localparam logic [ADDR_WIDTH-1:0] DEPTH_BOUND = ADDR_WIDTH'(DEPTH);

    logic p0_err_q;
    logic p1_err_q;

    assign grant_oob = (grant_addr >= DEPTH_BOUND);

    always_ff @(posedge clk) begin
        if (reset) begin
            oob_flag <= 1'b0;
            p0_err_q <= 1'b0;
            p1_err_q <= 1'b0;
        end else begin
            if (grant0 || grant1) begin
                oob_flag <= grant_oob;
            end
            if (state == READ) begin
                if (!owner) begin
                    p0_err_q <= oob_flag;
                end else begin
                    p1_err_q <= oob_flag;
                end
            end
        end
    end

    assign p0_rsp_err = p0_err_q;
    assign p1_rsp_err = p1_err_q;
`else
    assign grant_oob  = 1'b0;
    assign oob_flag   = 1'b0;
    assign p0_rsp_err = 1'b0;
    assign p1_rsp_err = 1'b0;
`endif

endmodule
